// File: rtl/logical_solver.sv
// Enumerates every {A,B,C,D,E,F} tuple whose predicate matches the target.
// Optional abort input under LOGICAL_SOLVER_ABORT_EN.
module logical_solver #(
  parameter int W     = 3,
  parameter int CNT_W = 6*W+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             target,
  input  logic [CNT_W-1:0] max_count,
`ifdef LOGICAL_SOLVER_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [W-1:0]     out_c,
  output logic [W-1:0]     out_d,
  output logic [W-1:0]     out_e,
  output logic [W-1:0]     out_f,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam int CW = 6*W;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    EMIT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    tup_q, tup_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] mc_q, mc_d;
  logic             tgt_q, tgt_d;
  logic             vld_q, vld_d;

  logic [W-1:0] fa, fb, fc, fd, fe, ff;
  logic         pred, last, xfer, quota;

  assign fa = cnt_q[6*W-1 -: W];
  assign fb = cnt_q[5*W-1 -: W];
  assign fc = cnt_q[4*W-1 -: W];
  assign fd = cnt_q[3*W-1 -: W];
  assign fe = cnt_q[2*W-1 -: W];
  assign ff = cnt_q[W-1 -: W];

  assign pred  = (fa == fb) && ((fc > fd) || !(fe < ff));
  assign last  = &cnt_q;
  assign xfer  = vld_q && out_ready;
  assign quota = (max_q != '0) && (mc_q + 1'b1 == max_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tup_d   = tup_q;
    max_d   = max_q;
    mc_d    = mc_q;
    tgt_d   = tgt_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target;
          max_d   = max_count;
          cnt_d   = '0;
          mc_d    = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (pred == tgt_q) begin
          tup_d   = cnt_q;
          vld_d   = 1'b1;
          state_d = EMIT;
        end else if (last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (xfer) begin
          mc_d  = mc_q + 1'b1;
          vld_d = 1'b0;
          if (quota || last) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SEARCH;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LOGICAL_SOLVER_ABORT_EN
    // abort wins over a same-cycle transfer, so that transfer is not counted
    if (abort && (state_q == SEARCH || state_q == EMIT)) begin
      state_d = DONE;
      vld_d   = 1'b0;
      mc_d    = mc_q;
      cnt_d   = cnt_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tup_q   <= '0;
      max_q   <= '0;
      mc_q    <= '0;
      tgt_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tup_q   <= tup_d;
      max_q   <= max_d;
      mc_q    <= mc_d;
      tgt_q   <= tgt_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_a       = tup_q[6*W-1 -: W];
  assign out_b       = tup_q[5*W-1 -: W];
  assign out_c       = tup_q[4*W-1 -: W];
  assign out_d       = tup_q[3*W-1 -: W];
  assign out_e       = tup_q[2*W-1 -: W];
  assign out_f       = tup_q[W-1 -: W];
  assign busy        = (state_q == SEARCH) || (state_q == EMIT);
  assign done        = (state_q == DONE);
  assign match_count = mc_q;

endmodule

// File: tb/tb_logical_solver.sv
// Directed bench for logical_solver: W=3 instance for ordering/handshake,
// W=2 instance for full-space exhaustion counts.
module tb_logical_solver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        target = 1'b0;
  logic [18:0] max_count = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, busy, done;
  logic [2:0]  oa, ob, oc, od, oe, of;
  logic [18:0] mc;
  logic [17:0] tup;
  assign tup = {oa, ob, oc, od, oe, of};

  logic        start2 = 1'b0;
  logic        target2 = 1'b0;
  logic [12:0] max2 = '0;
  logic        ready2 = 1'b0;
  logic        valid2, busy2, done2;
  logic [1:0]  a2, b2, c2, d2, e2, f2;
  logic [12:0] mc2;

`ifdef LOGICAL_SOLVER_ABORT_EN
  logic abort = 1'b0;
  logic abort2 = 1'b0;
`endif

  logical_solver u_dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .max_count(max_count),
`ifdef LOGICAL_SOLVER_ABORT_EN
    .abort(abort),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(oa), .out_b(ob), .out_c(oc), .out_d(od), .out_e(oe), .out_f(of),
    .busy(busy), .done(done), .match_count(mc)
  );

  logical_solver #(.W(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start2), .target(target2),
    .max_count(max2),
`ifdef LOGICAL_SOLVER_ABORT_EN
    .abort(abort2),
`endif
    .out_valid(valid2), .out_ready(ready2),
    .out_a(a2), .out_b(b2), .out_c(c2), .out_d(d2), .out_e(e2), .out_f(f2),
    .busy(busy2), .done(done2), .match_count(mc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic t, input logic [18:0] m);
    target = t;
    max_count = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_tuple(input string tag, input logic [17:0] exp);
    int i;
    for (i = 0; i < 400 && !out_valid; i++) tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk(tag, tup, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [18:0] exp_mc);
    int i;
    for (i = 0; i < 400 && !done; i++) tick();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_mc"}, mc, exp_mc);
    tick();
  endtask

  task automatic exhaust2(input string tag, input logic t,
                          input logic [12:0] exp_mc);
    int i;
    target2 = t;
    max2 = '0;
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (i = 0; i < 20000 && !done2; i++) tick();
    chk({tag, "_done"}, done2, 1'b1);
    chk({tag, "_mc"}, mc2, exp_mc);
    ready2 = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mc", mc, 0);
    chk("rst_tuple", tup, 0);
    rst = 1'b0;
    tick();

    // first match at index 0 appears two cycles after start
    go(1'b1, 19'd1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_early_valid", out_valid, 1'b0);
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_tuple", tup, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_done", done, 1'b1);
    chk("t1_drop", out_valid, 1'b0);
    chk("t1_mc", mc, 1);
    tick();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_idle", busy, 1'b0);

    go(1'b1, 19'd2);
    expect_tuple("t2_first", 18'o000000);
    expect_tuple("t2_second", 18'o000010);
    wait_done("t2", 19'd2);

    go(1'b0, 19'd1);
    expect_tuple("t3_first", 18'o000001);
    wait_done("t3", 19'd1);

    go(1'b1, 19'd2);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_tuple", tup, 0);
    end
    expect_tuple("bp_first", 18'o000000);
    expect_tuple("bp_next", 18'o000010);
    wait_done("bp", 19'd2);

    // a start pulse while busy must not restart or retarget
    go(1'b1, 19'd3);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    target = 1'b0;
    max_count = 19'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_tuple("ign_0", 18'o000000);
    expect_tuple("ign_1", 18'o000010);
    expect_tuple("ign_2", 18'o000011);
    wait_done("ign", 19'd3);

    go(1'b0, 19'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_busy_rst", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_mc", mc, 0);
    chk("mid_tuple", tup, 0);
    rst = 1'b0;
    tick();

    exhaust2("w2_t1", 1'b1, 13'd784);
    exhaust2("w2_t0", 1'b0, 13'd3312);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
